// File: rtl/share_arb_pkg.sv
// share_arb_pkg: shared types and helpers for the shared-unit arbiter.
// The tag struct carries {valid, id} down the fixed-latency tag pipeline.
package share_arb_pkg;

  // Storage width of a tag id. Each instance uses only the values 0..NREQ-1,
  // so this supports NREQ up to 256.
  localparam int TAG_ID_W = 8;

  // Width needed to hold a requester index (never less than one bit).
  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/share_arb_rr.sv
// share_arb_rr: round-robin picker. It grants the first eligible index at
// or after i_ptr, wrapping modulo NREQ. The output is one-hot, or zero when
// no index is eligible.
module share_arb_rr
  import share_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] i_elig,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant
);

  logic [NREQ-1:0] w_mask;     // indices at or after the pointer
  logic [NREQ-1:0] w_hi;       // eligible indices at or after the pointer
  logic [NREQ-1:0] w_hi_pick;
  logic [NREQ-1:0] w_lo_pick;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_mask
      assign w_mask[gi] = (gi >= int'(i_ptr));
    end
  endgenerate

  assign w_hi = i_elig & w_mask;

  // Isolate the lowest set bit. If nothing is eligible at or after the
  // pointer, wrap around and take the lowest eligible index overall.
  assign w_hi_pick = w_hi & (~w_hi + NREQ'(1));
  assign w_lo_pick = i_elig & (~i_elig + NREQ'(1));
  assign o_grant   = (|w_hi) ? w_hi_pick : w_lo_pick;

endmodule

// File: rtl/share_arb_ctrl.sv
// share_arb_ctrl: arbitrates NREQ requesters onto one shared pipelined unit
// with a fixed latency of DEPTH cycles. A tag pipeline routes each result
// back to the requester that issued it. Each requester may have at most
// MAX_OUT operations in flight.
// Optional feature: define SHARE_ARB_CTRL_STATS_EN to add a 16-bit wrapping
// issue counter output, issue_count.
module share_arb_ctrl
  import share_arb_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int DEPTH   = 2,
  parameter int NREQ    = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      unit_in0,
  output logic [WIDTH-1:0]      unit_in1,
  input  logic [WIDTH-1:0]      unit_out0,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  input  logic                  drain,
`ifdef SHARE_ARB_CTRL_STATS_EN
  output logic [15:0]           issue_count,
`endif
  output logic                  idle
);

  localparam int IDW  = id_width(NREQ);
  localparam int CNTW = $clog2(MAX_OUT + 1);

  logic [IDW-1:0]  r_rr_ptr;
  logic [CNTW-1:0] r_outstanding [NREQ];
  tag_t            r_tag [DEPTH];

  logic [NREQ-1:0]  w_elig;
  logic [NREQ-1:0]  w_grant;
  logic             w_issue;
  logic [IDW-1:0]   w_idx_chain [NREQ+1];
  logic [WIDTH-1:0] w_a_chain   [NREQ+1];
  logic [WIDTH-1:0] w_b_chain   [NREQ+1];
  logic [IDW-1:0]   w_grant_idx;
  logic [DEPTH-1:0] w_stage_valid;
  tag_t             w_tag_in;
  tag_t             w_tail;

  genvar gi;

  // Eligibility: requesting, below the in-flight limit, and not draining.
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_elig
      assign w_elig[gi] = req_valid[gi] & (r_outstanding[gi] < CNTW'(MAX_OUT)) & ~drain;
    end
  endgenerate

  share_arb_rr #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .i_elig  (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant)
  );

  // The grant is held off combinationally while reset is asserted, so no
  // requester sees a handshake during reset even if req_valid is high.
  assign req_ready = rst_n ? w_grant : '0;
  assign w_issue   = |(req_valid & req_ready);

  // Because the grant is one-hot, OR chains act as the index encoder and
  // the operand mux. With no grant, everything collapses to zero.
  assign w_idx_chain[0] = '0;
  assign w_a_chain[0]   = '0;
  assign w_b_chain[0]   = '0;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_mux
      assign w_idx_chain[gi+1] = w_idx_chain[gi] | (req_ready[gi] ? IDW'(gi) : '0);
      assign w_a_chain[gi+1]   = w_a_chain[gi] | (req_ready[gi] ? req_a[gi*WIDTH +: WIDTH] : '0);
      assign w_b_chain[gi+1]   = w_b_chain[gi] | (req_ready[gi] ? req_b[gi*WIDTH +: WIDTH] : '0);
    end
  endgenerate

  assign w_grant_idx = w_idx_chain[NREQ];
  assign unit_in0    = w_a_chain[NREQ];
  assign unit_in1    = w_b_chain[NREQ];

  // Tag entering the pipeline; the id is forced to zero when nothing issues.
  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_issue;
    if (w_issue) begin
      w_tag_in.id = TAG_ID_W'(w_grant_idx);
    end
  end

  // Tag pipeline stages; stage DEPTH-1 lines up with unit_out0.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        // Capture the issued tag.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_tag[gi] <= '0;
          else        r_tag[gi] <= w_tag_in;
        end
      end else begin : g_body
        // Shift the tag one stage toward the output.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_tag[gi] <= '0;
          else        r_tag[gi] <= r_tag[gi-1];
        end
      end
      assign w_stage_valid[gi] = r_tag[gi].valid;
    end
  endgenerate

  assign w_tail   = r_tag[DEPTH-1];
  assign rsp_data = w_tail.valid ? unit_out0 : '0;
  assign idle     = ~|w_stage_valid;

  // Per-requester response strobe and in-flight counter.
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign rsp_valid[gi] = w_tail.valid & (w_tail.id == TAG_ID_W'(gi));

      // Count up on issue and down on retire; both together cancel out.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_outstanding[gi] <= '0;
        end else begin
          case ({req_ready[gi] & req_valid[gi], rsp_valid[gi]})
            2'b10:   r_outstanding[gi] <= r_outstanding[gi] + CNTW'(1);
            2'b01:   r_outstanding[gi] <= r_outstanding[gi] - CNTW'(1);
            default: r_outstanding[gi] <= r_outstanding[gi];
          endcase
        end
      end
    end
  endgenerate

  // After an issue, the pointer moves to the index just past the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_issue) begin
      r_rr_ptr <= (w_grant_idx == IDW'(NREQ - 1)) ? '0 : w_grant_idx + IDW'(1);
    end
  end

`ifdef SHARE_ARB_CTRL_STATS_EN
  logic [15:0] r_issue_count;

  // Count issues, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_issue_count <= '0;
    else if (w_issue) r_issue_count <= r_issue_count + 16'd1;
  end

  assign issue_count = r_issue_count;
`endif

endmodule

// File: doc/share_arb_ctrl.md
SHARE_ARB_CTRL -- requirements
Module: share_arb_ctrl

Interface
- REQ-001 Parameter WIDTH, default 6, operand/result width of the shared unit.
- REQ-002 Parameter DEPTH, default 2, fixed latency of the shared unit in cycles; legal range >= 1.
- REQ-003 Parameter NREQ, default 4, number of requesters; legal range >= 2.
- REQ-004 Parameter MAX_OUT, default 2, maximum in-flight operations per requester; legal range >= 1.
- REQ-005 clk  input  1  sole clock, rising edge.
- REQ-006 rst_n  input  1  asynchronous, active-low reset.
- REQ-007 req_valid  input  NREQ  per-requester operation request.
- REQ-008 req_ready  output  NREQ  per-requester grant, one-hot or zero.
- REQ-009 req_a, req_b  input  NREQ*WIDTH each  packed operands; requester i occupies bits [i*WIDTH +: WIDTH].
- REQ-010 unit_in0, unit_in1  output  WIDTH each  operands to the shared unit.
- REQ-011 unit_out0  input  WIDTH  shared unit result.
- REQ-012 rsp_valid  output  NREQ  one-hot result strobe; no backpressure.
- REQ-013 rsp_data  output  WIDTH  result, valid when any rsp_valid bit is set.
- REQ-014 drain  input  1  quiesce request.
- REQ-015 idle  output  1  no operation in flight.

Function
- REQ-016 Eligible(i) = req_valid[i] & outstanding[i] < MAX_OUT & ~drain; outstanding[i] is registered.
- REQ-017 Round-robin grant: first eligible index at or after rr_ptr, wrapping modulo NREQ; req_ready is combinational from eligibility.
- REQ-018 Issue = req_valid[i] & req_ready[i]; rr_ptr updates to (i+1) mod NREQ on issue only.
- REQ-019 Issue cycle: unit_in0/unit_in1 = the granted requester's req_a/req_b, combinationally; no issue: both are 0.
- REQ-020 Tag pipeline: DEPTH registered stages of {valid, id}; issue at cycle t produces rsp_valid[id]=1 and rsp_data=unit_out0 at cycle t+DEPTH.
- REQ-021 No tag valid at the pipeline output: rsp_valid=0 and rsp_data=0.
- REQ-022 outstanding[i] increments on issue and decrements on retire, both in the next cycle; simultaneous issue and retire for the same i leaves it unchanged.
- REQ-023 Throughput: one issue per cycle maximum, back-to-back allowed.
- REQ-024 drain=1 forces req_ready=0 in the same cycle; in-flight operations still retire.
- REQ-025 idle=1 iff every tag stage is invalid, independent of drain.

Reset
- REQ-026 rst_n low: tag stages invalid, outstanding=0, rr_ptr=0, rsp_valid=0, rsp_data=0, idle=1, and req_ready=0 for as long as reset is held.
- REQ-027 Reset asserted mid-operation discards every in-flight result: no rsp_valid for those operations after release.

Configuration
- REQ-028 Macro SHARE_ARB_CTRL_STATS_EN defined: adds output issue_count (16 bits), incremented on every issue, wrapping 0xFFFF->0, reset to 0.
- REQ-029 Macro SHARE_ARB_CTRL_STATS_EN undefined: issue_count and its counter are absent; all other behaviour is identical.

Structure
- REQ-030 Package share_arb_pkg holds the tag struct type (valid, id) and the id-width localparam function ($clog2(NREQ), minimum 1).
- REQ-031 Sub-module share_arb_rr implements the round-robin picker: eligibility vector and pointer in, one-hot grant out.

Verification (bench models the shared unit as out0 = in0+in1 mod 2^WIDTH with DEPTH latency)
- REQ-032 Defaults; req 0 only, a=5, b=3, valid at cycle 1 -> req_ready[0]=1 at cycle 1; rsp_valid=0001 and rsp_data=8 at cycle 3; idle=0 in cycles 2-3.
- REQ-033 All four valid from cycle 0, MAX_OUT=4 -> grants 0,1,2,3,0 on consecutive cycles; responses in the same order, DEPTH cycles later.
- REQ-034 DEPTH=4, MAX_OUT=2, req 1 only, valid continuously -> issues at cycles 0 and 1, stalls in cycles 2-4, retires at 4, next issue at cycle 5.
- REQ-035 Two operations in flight, drain=1 held -> req_ready=0 throughout; both responses arrive; idle=1 the cycle after the last retire.
- REQ-036 rst_n low for one cycle with 2 in flight -> all outputs at reset values; no rsp_valid for the dropped operations; a new request after release is granted to requester 0 first.
- REQ-037 With SHARE_ARB_CTRL_STATS_EN, 65537 issues -> issue_count=1.
